// File: rtl/uart_ram_loader_if.sv
// RAM write port driven by the UART loader; the top level muxes it with the CPU data port.
interface uart_ram_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/uart_ram_loader.sv
// Receives a framed 8N1 UART packet (A5, LEN_HI, LEN_LO, LEN big-endian words)
// and writes the words sequentially into RAM, holding busy for the whole load.
module uart_ram_loader #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 12,
   parameter int START_ADDR   = 0,
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 5000000
) (
   input  logic              CLK_50,
   input  logic              resetN,
   input  logic              rx,
   uart_ram_loader_if.master wr,
   output logic              busy,
   output logic              done,
   output logic              err_frame,
   output logic              err_len,
   output logic              err_timeout
);

   localparam int BIT_CW = $clog2(CLKS_PER_BIT);
   localparam int TO_CW  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [16:0]           CAPACITY  = 17'((1 << ADDR_WIDTH) - START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(START_ADDR);
   localparam logic [BIT_CW-1:0]     HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_CW-1:0]     BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
   localparam logic [TO_CW-1:0]      TO_LAST   = TO_CW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, FINISH} state_t;

   rx_state_t             rx_state;
   logic                  rx_meta, rx_sync, rx_prev;
   logic [BIT_CW-1:0]     bit_cnt;
   logic [2:0]            bit_idx;
   logic [7:0]            shift;
   logic                  byte_valid, stop_err;

   state_t                state;
   logic [7:0]            len_hi, data_hi;
   logic [15:0]           len, index;
   logic [TO_CW-1:0]      to_cnt;
   logic                  we_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [15:0]           len_rx;
   logic [16:0]           index_next;

   assign len_rx     = {len_hi, shift};
   assign index_next = {1'b0, index} + 17'd1;
   assign wr.we      = we_r;
   assign wr.addr    = addr_r;
   assign wr.wdata   = wdata_r;

   // Byte sampler: start edge, half-bit start re-check, then one sample per bit period.
   always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  bit_cnt  <= '0;
               end
            end
            RX_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) byte_valid <= 1'b1;
                  else         stop_err   <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Packet parser; a framing error or inter-byte timeout abandons the packet from any state.
   always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_frame   <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         len_hi      <= '0;
         data_hi     <= '0;
         len         <= '0;
         index       <= '0;
         to_cnt      <= '0;
         we_r        <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
      end else begin
         we_r <= 1'b0;
         done <= 1'b0;
         if (!busy || byte_valid) to_cnt <= '0;
         else                     to_cnt <= to_cnt + 1'b1;

         if (stop_err) begin
            err_frame <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
         end else if (busy && !byte_valid && to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (byte_valid && shift == 8'hA5) begin
                     busy  <= 1'b1;
                     state <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  if (byte_valid) begin
                     len_hi <= shift;
                     state  <= LEN_LO;
                  end
               end
               LEN_LO: begin
                  if (byte_valid) begin
                     if (len_rx == 16'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else if ({1'b0, len_rx} > CAPACITY) begin
                        err_len <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                     end else begin
                        len   <= len_rx;
                        index <= '0;
                        state <= DATA_HI;
                     end
                  end
               end
               DATA_HI: begin
                  if (byte_valid) begin
                     data_hi <= shift;
                     state   <= DATA_LO;
                  end
               end
               DATA_LO: begin
                  if (byte_valid) begin
                     we_r    <= 1'b1;
                     addr_r  <= BASE + index[ADDR_WIDTH-1:0];
                     wdata_r <= {data_hi, shift};
                     index   <= index_next[15:0];
                     state   <= (index_next == {1'b0, len}) ? FINISH : DATA_HI;
                  end
               end
               FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader: byte streams go through a packet-level
// model that predicts RAM writes, done pulses and error flags.
module tb_uart_ram_loader;

   localparam int CPB   = 8;
   localparam int TO    = 100;
   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int START = 0;
   localparam int CAP   = (1 << AW) - START;

   typedef logic [7:0] byte_q_t[$];

   logic CLK_50 = 1'b0;
   logic resetN = 1'b0;
   logic rx     = 1'b1;
   logic busy, done, err_frame, err_len, err_timeout;

   uart_ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wr_bus ();

   uart_ram_loader #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .START_ADDR  (START),
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .CLK_50     (CLK_50),
      .resetN     (resetN),
      .rx         (rx),
      .wr         (wr_bus),
      .busy       (busy),
      .done       (done),
      .err_frame  (err_frame),
      .err_len    (err_len),
      .err_timeout(err_timeout)
   );

   always #5 CLK_50 = ~CLK_50;

   int               n_checks = 0;
   int               n_fail   = 0;
   int               done_cnt = 0;
   int               exp_done = 0;
   bit               exp_len_err = 1'b0;
   logic [AW+DW-1:0] exp_q[$];
   logic             prev_we = 1'b0;
   logic [2:0]       prev_flags = 3'b000;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Packet-level reference: find sync, read the length, emit one write per word pair.
   task automatic model_stream(input byte_q_t s);
      int i;
      int len;
      i = 0;
      while (i < s.size()) begin
         if (s[i] != 8'hA5 || i + 2 >= s.size()) begin
            i++;
            continue;
         end
         len = {16'd0, s[i+1], s[i+2]};
         i += 3;
         if (len == 0) begin
            exp_done++;
         end else if (len > CAP) begin
            exp_len_err = 1'b1;
         end else begin
            for (int k = 0; k < len; k++)
               exp_q.push_back({AW'(START + k), s[i+2*k], s[i+2*k+1]});
            i += 2 * len;
            exp_done++;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge CLK_50);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge CLK_50);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge CLK_50);
      rx = 1'b1;
      repeat (CPB) @(negedge CLK_50);
   endtask

   task automatic apply_stimulus(input byte_q_t s);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic end_test(input string name, input bit ef, input bit el, input bit et);
      repeat (4) @(negedge CLK_50);
      check_output({name, "_done_count"}, done_cnt, exp_done);
      check_output({name, "_writes_left"}, exp_q.size(), 0);
      check_output({name, "_busy"}, busy, 1'b0);
      check_output({name, "_err_frame"}, err_frame, ef);
      check_output({name, "_err_len"}, err_len, el);
      check_output({name, "_err_timeout"}, err_timeout, et);
      done_cnt = 0;
      exp_done = 0;
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, "_we"}, wr_bus.we, 1'b0);
      check_output({name, "_addr"}, wr_bus.addr, '0);
      check_output({name, "_wdata"}, wr_bus.wdata, '0);
      check_output({name, "_busy"}, busy, 1'b0);
      check_output({name, "_done"}, done, 1'b0);
      check_output({name, "_flags"}, {err_frame, err_len, err_timeout}, 3'b000);
   endtask

   // Per-cycle compare of the write port and pulse/sticky behaviour against the model.
   always @(negedge CLK_50) begin
      if (resetN) begin
         if (wr_bus.we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_we: got write addr 0x%0h data 0x%0h, required no write",
                        wr_bus.addr, wr_bus.wdata);
            end else begin
               logic [AW+DW-1:0] e;
               e = exp_q.pop_front();
               check_output("write_addr", wr_bus.addr, e[AW+DW-1:DW]);
               check_output("write_data", wr_bus.wdata, e[DW-1:0]);
            end
            check_output("we_single_cycle", prev_we, 1'b0);
         end
         if (done) begin
            done_cnt++;
            check_output("busy_low_at_done", busy, 1'b0);
            check_output("no_we_at_done", wr_bus.we, 1'b0);
         end
         if (prev_flags != 3'b000)
            check_output("flags_sticky", {err_frame, err_len, err_timeout} & prev_flags, prev_flags);
         prev_we    = wr_bus.we;
         prev_flags = {err_frame, err_len, err_timeout};
      end else begin
         prev_we    = 1'b0;
         prev_flags = 3'b000;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      byte_q_t    pkt;
      int         waited;
      int         len;
      logic [7:0] b;

      resetN = 1'b0;
      rx     = 1'b1;
      repeat (3) @(negedge CLK_50);
      check_all_zero("reset");
      resetN = 1'b1;
      repeat (4) @(negedge CLK_50);

      $display("[TB] basic two-word packet");
      pkt = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      model_stream(pkt);
      check_output("model_basic_count", exp_q.size(), 2);
      check_output("model_basic_w0", exp_q[0], 28'h000_1234);
      check_output("model_basic_w1", exp_q[1], 28'h001_ABCD);
      check_output("model_basic_done", exp_done, 1);
      apply_stimulus(pkt);
      end_test("basic", 1'b0, 1'b0, 1'b0);

      $display("[TB] leading junk and A5 as data");
      pkt = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h01, 8'h00, 8'hA5};
      model_stream(pkt);
      check_output("model_junk_w0", exp_q[0], 28'h000_00A5);
      apply_stimulus(pkt);
      end_test("junk", 1'b0, 1'b0, 1'b0);

      $display("[TB] zero-length packet");
      pkt = '{8'hA5, 8'h00, 8'h00};
      model_stream(pkt);
      check_output("model_zero_done", exp_done, 1);
      check_output("model_zero_writes", exp_q.size(), 0);
      apply_stimulus(pkt);
      end_test("zero_len", 1'b0, 1'b0, 1'b0);

      $display("[TB] oversize length then recovery");
      pkt = '{8'hA5, 8'h10, 8'h01};
      model_stream(pkt);
      check_output("model_oversize_err", exp_len_err, 1'b1);
      apply_stimulus(pkt);
      end_test("oversize", 1'b0, 1'b1, 1'b0);
      pkt = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
      model_stream(pkt);
      check_output("model_recover_w0", exp_q[0], 28'h000_BEEF);
      apply_stimulus(pkt);
      end_test("recover", 1'b0, 1'b1, 1'b0);

      $display("[TB] framing error on LEN_LO");
      send_byte(8'hA5);
      send_byte(8'h00);
      check_output("frame_busy_before", busy, 1'b1);
      send_byte(8'h02, 1'b0);
      end_test("frame_err", 1'b1, 1'b1, 1'b0);

      $display("[TB] randomized packets");
      for (int p = 0; p < 12; p++) begin
         pkt = {};
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            pkt.push_back(b);
         end
         pkt.push_back(8'hA5);
         if ($urandom_range(0, 9) == 0) len = int'($urandom_range(CAP + 1, 65535));
         else                           len = int'($urandom_range(0, 5));
         pkt.push_back(8'(len >> 8));
         pkt.push_back(8'(len));
         if (len <= CAP)
            for (int j = 0; j < 2 * len; j++) pkt.push_back(8'($urandom_range(0, 255)));
         model_stream(pkt);
         apply_stimulus(pkt);
         repeat (4) @(negedge CLK_50);
      end
      end_test("random", 1'b1, 1'b1, 1'b0);

      $display("[TB] inter-byte timeout");
      apply_stimulus('{8'hA5, 8'h00, 8'h02, 8'h12});
      check_output("timeout_busy_before", busy, 1'b1);
      waited = 0;
      while (!err_timeout && waited < 150) begin
         @(negedge CLK_50);
         waited++;
      end
      check_output("timeout_flag", err_timeout, 1'b1);
      check_output("timeout_latency_window", (waited >= 60 && waited <= 100), 1'b1);
      end_test("timeout", 1'b1, 1'b1, 1'b1);

      $display("[TB] reset in the middle of a word");
      apply_stimulus('{8'hA5, 8'h00, 8'h02, 8'h12});
      check_output("midreset_busy_before", busy, 1'b1);
      resetN = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (3) @(negedge CLK_50);
      resetN = 1'b1;
      repeat (2) @(negedge CLK_50);
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'hC3};
      model_stream(pkt);
      apply_stimulus(pkt);
      end_test("after_reset", 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Serial-to-RAM writer: the write-side counterpart of the screen read port on the data RAM.
- Receives an 8N1 UART byte stream and assembles a framed packet into DATA_WIDTH-bit words.
- Writes the words sequentially into RAM through a write port that is muxed with the CPU data port.
- Asserts busy during a load; top level uses busy to hold the CPU in reset so RAM/screen contents can be loaded from a host without re-synthesis.

Parameters:
- DATA_WIDTH, 16: word width; fixed at 16 (two bytes per word).
- ADDR_WIDTH, 12: RAM address width; capacity = 2**ADDR_WIDTH words.
- START_ADDR, 0: first RAM address written by a packet.
- CLKS_PER_BIT, 434: CLK_50 cycles per UART bit (50 MHz / 115200); minimum 4.
- TIMEOUT_CLKS, 5000000: idle cycles allowed between bytes inside a packet before abort.

Ports:
- CLK_50  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- rx  in  1  UART line, idle high, asynchronous to CLK_50.
- we  out  1  RAM write strobe, one-cycle pulse per word.
- addr  out  ADDR_WIDTH  RAM write address.
- wdata  out  DATA_WIDTH  RAM write data.
- busy  out  1  high from accepted sync byte until the packet ends (done or error).
- done  out  1  one-cycle pulse after the last word is written, or after LEN_LO when length is 0.
- err_frame  out  1  sticky: a stop bit was sampled low.
- err_len  out  1  sticky: length exceeded 2**ADDR_WIDTH - START_ADDR.
- err_timeout  out  1  sticky: inter-byte timeout expired while busy.

Behaviour:
- Reset (async, resetN low): all outputs 0, FSM = IDLE; the synchronizer flops and the internal rx sample reset to 1. Reset mid-packet discards the partial packet; no further we.
- RX sampler:
  - rx passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if high, the frame is treated as a glitch and ignored.
  - The 8 data bits are then sampled LSB first, one every CLKS_PER_BIT cycles, followed by the stop bit.
  - Stop bit high: byte_valid pulses for 1 cycle.
  - Stop bit low: no byte_valid, err_frame is set, the FSM returns to IDLE (busy drops) and the partial packet is abandoned.
  - The sampler re-arms to detect a new start edge immediately after the stop-bit sample.
- Packet format: 0xA5, LEN_HI, LEN_LO, then LEN words, each sent high byte first. LEN is 16 bits unsigned.
- FSM on byte_valid:
  - IDLE: 0xA5 -> LEN_HI and busy=1; any other byte is ignored.
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - LEN = 0 -> done pulse, busy=0, IDLE.
    - LEN > 2**ADDR_WIDTH - START_ADDR -> err_len=1, busy=0, IDLE, no writes.
    - Otherwise -> DATA_HI with index=0.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO:
    - In the cycle after byte_valid: we=1, addr=START_ADDR+index, wdata={hi,lo}; index then increments.
    - If index+1 = LEN: done pulses in the cycle after we, busy falls in that same cycle, and the FSM returns to IDLE.
    - Otherwise -> DATA_HI.
- addr/wdata hold their last values when we=0.
- Timeout: a counter resets on every byte_valid and is active only while busy. Reaching TIMEOUT_CLKS sets err_timeout, busy=0, IDLE; no partial-word write occurs.
- Sticky errors are cleared only by reset. A new packet is accepted after any error.
- Write latency: exactly 1 cycle from the byte_valid of a low byte to we.
- 0xA5 bytes inside the length or data fields are treated as data, not as sync.

Test Plan:
- CLKS_PER_BIT=8; send A5 00 02 12 34 AB CD -> we at addr 0 with 0x1234, then at addr 1 with 0xABCD; done pulses once; busy low afterwards; no error flags.
- Send 00 FF 3C before A5 00 01 00 A5 -> leading bytes ignored; single write 0x00A5 at addr 0; done pulses.
- Send A5 00 00 -> done pulses in the cycle after LEN_LO's byte_valid; we never asserted.
- ADDR_WIDTH=12, START_ADDR=0; send A5 10 01 -> err_len=1, busy=0, no we. Then A5 00 01 BE EF -> write 0xBEEF at addr 0.
- Send A5 00 02 with the stop bit of LEN_LO forced low -> err_frame=1, busy=0, no we.
- TIMEOUT_CLKS=100: send A5 00 02 12, then stay idle -> err_timeout=1 and busy=0 within 100 cycles of the last stop sample.
- Pulse resetN low while in DATA_LO -> all outputs 0 immediately.
